lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit sitting between the execute stage and the word-organised data memory. Accepts one byte-addressed load or store per request, checks alignment, converts it into whole-word DMEM accesses (read-modify-write for sb/sh), and returns lane-selected, sign/zero-extended load data. DMEM is always driven in word mode (funct3 = 010) with a registered read port, so every byte/halfword detail lives here.

## Interface
- ADDR_W, 10, DMEM word-address width (DMEM depth = 2^ADDR_W words)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- MemRW  in  1  1 = store, 0 = load
- funct3  in  3  RV32I load/store funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
- ALU_addr  in  32  byte address
- DataW  in  32  store data (low byte/half used for sb/sh)
- resp_valid  out  1  one-cycle completion pulse
- DataR  out  32  formatted load result, held until next load response
- misalign  out  1  qualifies resp_valid: request rejected, no memory access made
- mem_we  out  1  DMEM write enable (to DMEM MemRW)
- mem_funct3  out  3  constant 3'b010
- mem_addr  out  ADDR_W  word address = ALU_addr[ADDR_W+1:2]
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  DMEM read word, valid the cycle after mem_addr presented with mem_we = 0

## Operation
- Handshake: request accepted on rising edge with req_valid & req_ready; MemRW, funct3, ALU_addr, DataW latched then. Inputs ignored at all other times.
- States: IDLE, RD, CAP, WR, RESP, ERR.
- IDLE: on accept, go ERR if illegal, WR if sw, else RD.
- Illegal: funct3 in {011,110,111}; stores with funct3 100/101; h/hu with addr[0]=1; w with addr[1:0]≠00.
- RD: mem_we=0, mem_addr driven → CAP.
- CAP: mem_rdata valid. Load: register formatted DataR → RESP. sb/sh: register merged word into mem_wdata → WR.
- WR: mem_we=1, mem_addr driven, mem_wdata = DataW (sw) or merged word → RESP.
- RESP: resp_valid=1, misalign=0 → IDLE. ERR: resp_valid=1, misalign=1 → IDLE; DataR unchanged.
- Lanes little-endian, off = addr[1:0]. lb/lbu: byte mem_rdata[8*off+7:8*off], sign/zero-extend to 32. lh/lhu: half at [16*addr[1]+15:16*addr[1]], sign/zero-extend. lw: word as-is.
- Merge: sb replaces byte lane off with DataW[7:0]; sh replaces half lane addr[1] with DataW[15:0]; other bits from mem_rdata.
- ALU_addr bits above ADDR_W+1 ignored (address wraps modulo DMEM size); no fault.
- mem_we high in WR only; mem_addr don't-care outside RD/CAP/WR but held at latched address.

## Timing
- Cycle 0 = accept edge. lw/lb/lh/lbu/lhu: resp_valid in cycle 3. sw: mem_we cycle 1, resp cycle 2. sb/sh: RD 1, CAP 2, WR 3, resp 4. Illegal: resp cycle 1.
- Back-to-back: new request accepted in the cycle after RESP/ERR (IDLE); minimum spacing = latency + 1.
- Reset (async, any state): state → IDLE, resp_valid=0, misalign=0, mem_we=0, DataR=0, mem_wdata=0, mem_addr=0, latched request cleared; req_ready=1 while in IDLE including during reset.
- Reset asserted before the WR edge of an RMW: no write reaches DMEM; partial RMW discarded.
- resp_valid never high for more than one consecutive cycle per request.

## Test plan
- lw at 0x0000_0008 with DMEM word[2]=0xDEADBEEF → mem_addr=2, resp_valid cycle 3, DataR=0xDEADBEEF, misalign=0.
- lb at 0x0000_000B then lbu same address, word[2]=0x80FF_1234 → DataR=0xFFFF_FF80 then 0x0000_0080.
- sb DataW=0x0000_00AA at 0x0000_0005, word[1]=0x1122_3344 → mem_we only in cycle 3, mem_wdata=0x1122_AA44, resp cycle 4; follow-up lw returns 0x1122_AA44.
- sh at 0x0000_0003 and lw at 0x0000_0006 → each resp_valid cycle 1 with misalign=1, mem_we never asserted, DataR unchanged.
- sh DataW=0xBEEF at 0x0000_0002 over 0x1234_5678 → 0xBEEF_5678; funct3=011 load → misalign=1.
- Start sb, drop rst_n during CAP → outputs zero immediately, mem_we never high, DMEM word unchanged; after release, req_ready=1 and new lw completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns byte/half/word loads and stores into word-wide DMEM
// accesses (read-modify-write for sb/sh) and formats load results.
module lsu_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              MemRW,
   input  logic [2:0]        funct3,
   input  logic [31:0]       ALU_addr,
   input  logic [31:0]       DataW,
   output logic              resp_valid,
   output logic [31:0]       DataR,
   output logic              misalign,
   output logic              mem_we,
   output logic [2:0]        mem_funct3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD, S_CAP, S_WR, S_RESP, S_ERR
   } state_t;

   state_t            r_state;
   logic              r_store;
   logic [2:0]        r_funct3;
   logic [1:0]        r_off;
   logic [15:0]       r_data_w;
   logic              r_resp_valid;
   logic              r_misalign;
   logic              r_mem_we;
   logic [31:0]       r_data_r;
   logic [31:0]       r_mem_wdata;
   logic [ADDR_W-1:0] r_mem_addr;

   logic              w_illegal;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic [31:0]       w_merged;
   // Address bits above the DMEM range are deliberately dropped (wrap-around).
   logic              w_unused_addr;

   assign w_unused_addr = ^ALU_addr[31:ADDR_W+2];

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_illegal = 1'b1;
      case (funct3)
         3'b000:  w_illegal = 1'b0;
         3'b001:  w_illegal = ALU_addr[0];
         3'b010:  w_illegal = |ALU_addr[1:0];
         3'b100:  w_illegal = MemRW;
         3'b101:  w_illegal = MemRW | ALU_addr[0];
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
   assign w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];

   always_comb begin
      w_load = mem_rdata;
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'h0, w_byte};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = mem_rdata;
      endcase
   end

   // Only sb (000) and sh (001) reach the merge path, so funct3[0] picks the width.
   always_comb begin
      w_merged = mem_rdata;
      if (r_funct3[0]) w_merged[{r_off[1], 4'b0000} +: 16] = r_data_w;
      else             w_merged[{r_off, 3'b000} +: 8]      = r_data_w[7:0];
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_store      <= 1'b0;
         r_funct3     <= 3'b000;
         r_off        <= 2'b00;
         r_data_w     <= 16'h0;
         r_resp_valid <= 1'b0;
         r_misalign   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_data_r     <= 32'h0;
         r_mem_wdata  <= 32'h0;
         r_mem_addr   <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_misalign   <= 1'b0;
         r_mem_we     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_store    <= MemRW;
                  r_funct3   <= funct3;
                  r_off      <= ALU_addr[1:0];
                  r_data_w   <= DataW[15:0];
                  r_mem_addr <= ALU_addr[ADDR_W+1:2];
                  if (w_illegal) begin
                     r_state      <= S_ERR;
                     r_resp_valid <= 1'b1;
                     r_misalign   <= 1'b1;
                  end else if (MemRW && funct3 == 3'b010) begin
                     r_state     <= S_WR;
                     r_mem_we    <= 1'b1;
                     r_mem_wdata <= DataW;
                  end else begin
                     r_state <= S_RD;
                  end
               end
            end
            S_RD: r_state <= S_CAP;
            S_CAP: begin
               if (r_store) begin
                  r_mem_wdata <= w_merged;
                  r_mem_we    <= 1'b1;
                  r_state     <= S_WR;
               end else begin
                  r_data_r     <= w_load;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end
            end
            S_WR: begin
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP:  r_state <= S_IDLE;
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = r_resp_valid;
   assign misalign   = r_misalign;
   assign DataR      = r_data_r;
   assign mem_we     = r_mem_we;
   assign mem_funct3 = 3'b010;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a registered-read word DMEM model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        MemRW = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] ALU_addr = 32'h0;
   logic [31:0] DataW = 32'h0;
   logic        resp_valid;
   logic [31:0] DataR;
   logic        misalign;
   logic        mem_we;
   logic [2:0]  mem_funct3;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;

   logic [31:0] dmem [0:1023];
   logic        tb_we = 1'b0;
   logic [9:0]  tb_waddr = '0;
   logic [31:0] tb_wdata = '0;

   int          t_lat, t_we_cnt, t_we_cyc, t_acc;
   logic [31:0] t_we_data, t_dr;
   logic [9:0]  t_addr;
   logic        t_mis, t_after;

   lsu_ctrl #(.ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .MemRW(MemRW), .funct3(funct3), .ALU_addr(ALU_addr), .DataW(DataW),
      .resp_valid(resp_valid), .DataR(DataR), .misalign(misalign),
      .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (tb_we) dmem[tb_waddr] <= tb_wdata;
      else if (mem_we) dmem[mem_addr] <= mem_wdata;
      mem_rdata <= dmem[mem_addr];
   end

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Issues one request and records latency, write activity and response fields.
   task automatic run_req(input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      req_valid = 1'b1; MemRW = st; funct3 = f3; ALU_addr = addr; DataW = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      t_acc = edge_cnt; t_addr = mem_addr;
      t_lat = -1; t_we_cnt = 0; t_we_cyc = -1; t_we_data = '0; t_mis = 1'bx; t_dr = 'x; t_after = 1'bx;
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) begin @(posedge clk); #1; end
         if (mem_we) begin t_we_cnt++; t_we_cyc = c; t_we_data = mem_wdata; end
         if (resp_valid) begin t_lat = c; t_mis = misalign; t_dr = DataR; break; end
      end
      if (t_lat > 0) begin @(posedge clk); #1; t_after = resp_valid; end
   endtask

   task automatic test_reset;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b exp 1", req_ready); end
      checks++; if (resp_valid !== 1'b0 || misalign !== 1'b0 || mem_we !== 1'b0) begin
         failures++; $display("FAIL rst_ctrl got rv=%b mis=%b we=%b exp 0", resp_valid, misalign, mem_we); end
      checks++; if (DataR !== 32'h0 || mem_wdata !== 32'h0 || mem_addr !== 10'h0) begin
         failures++; $display("FAIL rst_data got DataR=%h wdata=%h addr=%h exp 0", DataR, mem_wdata, mem_addr); end
      checks++; if (mem_funct3 !== 3'b010) begin failures++; $display("FAIL mem_funct3 got %b exp 010", mem_funct3); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_lw;
      poke(10'd2, 32'hDEADBEEF);
      run_req(1'b0, 3'b010, 32'h0000_0008, 32'h0);
      checks++; if (t_addr !== 10'd2) begin failures++; $display("FAIL lw_addr got %0d exp 2", t_addr); end
      checks++; if (t_lat !== 3) begin failures++; $display("FAIL lw_lat got %0d exp 3", t_lat); end
      checks++; if (t_dr !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got %h exp deadbeef", t_dr); end
      checks++; if (t_mis !== 1'b0 || t_we_cnt !== 0) begin failures++; $display("FAIL lw_flags got mis=%b we=%0d exp 0/0", t_mis, t_we_cnt); end
      checks++; if (t_after !== 1'b0) begin failures++; $display("FAIL lw_pulse got %b exp 0", t_after); end
   endtask

   task automatic test_lb_lbu;
      poke(10'd2, 32'h80FF_1234);
      run_req(1'b0, 3'b000, 32'h0000_000B, 32'h0);
      checks++; if (t_dr !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb got %h exp ffffff80", t_dr); end
      run_req(1'b0, 3'b100, 32'h0000_000B, 32'h0);
      checks++; if (t_dr !== 32'h0000_0080) begin failures++; $display("FAIL lbu got %h exp 00000080", t_dr); end
      run_req(1'b0, 3'b001, 32'h0000_000A, 32'h0);
      checks++; if (t_dr !== 32'hFFFF_80FF) begin failures++; $display("FAIL lh got %h exp ffff80ff", t_dr); end
      run_req(1'b0, 3'b101, 32'h0000_0008, 32'h0);
      checks++; if (t_dr !== 32'h0000_1234 || t_lat !== 3) begin
         failures++; $display("FAIL lhu got %h lat %0d exp 00001234 lat 3", t_dr, t_lat); end
   endtask

   task automatic test_sb;
      poke(10'd1, 32'h1122_3344);
      run_req(1'b1, 3'b000, 32'h0000_0005, 32'h0000_00AA);
      checks++; if (t_we_cnt !== 1 || t_we_cyc !== 3) begin
         failures++; $display("FAIL sb_we got cnt=%0d cyc=%0d exp 1/3", t_we_cnt, t_we_cyc); end
      checks++; if (t_we_data !== 32'h1122_AA44) begin failures++; $display("FAIL sb_wdata got %h exp 1122aa44", t_we_data); end
      checks++; if (t_lat !== 4 || t_mis !== 1'b0) begin failures++; $display("FAIL sb_lat got %0d mis %b exp 4/0", t_lat, t_mis); end
      run_req(1'b0, 3'b010, 32'h0000_0004, 32'h0);
      checks++; if (t_dr !== 32'h1122_AA44) begin failures++; $display("FAIL sb_readback got %h exp 1122aa44", t_dr); end
   endtask

   task automatic test_sh_sw;
      poke(10'd0, 32'h1234_5678);
      run_req(1'b1, 3'b001, 32'h0000_0002, 32'h0000_BEEF);
      checks++; if (t_we_data !== 32'hBEEF_5678 || t_lat !== 4) begin
         failures++; $display("FAIL sh got %h lat %0d exp beef5678 lat 4", t_we_data, t_lat); end
      checks++; if (t_dr !== 32'h1122_AA44) begin failures++; $display("FAIL sh_datar got %h exp 1122aa44", t_dr); end
      run_req(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D);
      checks++; if (t_we_cyc !== 1 || t_we_cnt !== 1 || t_lat !== 2) begin
         failures++; $display("FAIL sw_timing got we_cyc=%0d cnt=%0d lat=%0d exp 1/1/2", t_we_cyc, t_we_cnt, t_lat); end
      checks++; if (dmem[4] !== 32'hCAFE_F00D || dmem[0] !== 32'hBEEF_5678) begin
         failures++; $display("FAIL store_mem got w4=%h w0=%h exp cafef00d/beef5678", dmem[4], dmem[0]); end
   endtask

   task automatic test_misalign;
      run_req(1'b1, 3'b001, 32'h0000_0003, 32'h0000_5555);
      checks++; if (t_lat !== 1 || t_mis !== 1'b1 || t_we_cnt !== 0) begin
         failures++; $display("FAIL sh_mis got lat=%0d mis=%b we=%0d exp 1/1/0", t_lat, t_mis, t_we_cnt); end
      checks++; if (t_dr !== 32'h1122_AA44) begin failures++; $display("FAIL mis_datar got %h exp 1122aa44", t_dr); end
      run_req(1'b0, 3'b010, 32'h0000_0006, 32'h0);
      checks++; if (t_lat !== 1 || t_mis !== 1'b1 || t_we_cnt !== 0 || t_dr !== 32'h1122_AA44) begin
         failures++; $display("FAIL lw_mis got lat=%0d mis=%b we=%0d dr=%h exp 1/1/0/1122aa44", t_lat, t_mis, t_we_cnt, t_dr); end
      run_req(1'b0, 3'b011, 32'h0000_0000, 32'h0);
      checks++; if (t_mis !== 1'b1 || t_lat !== 1) begin failures++; $display("FAIL f3_011 got mis=%b lat=%0d exp 1/1", t_mis, t_lat); end
      run_req(1'b1, 3'b100, 32'h0000_0000, 32'h0);
      checks++; if (t_mis !== 1'b1 || t_we_cnt !== 0) begin failures++; $display("FAIL sbu_store got mis=%b we=%0d exp 1/0", t_mis, t_we_cnt); end
      checks++; if (dmem[0] !== 32'hBEEF_5678) begin failures++; $display("FAIL mis_mem got %h exp beef5678", dmem[0]); end
   endtask

   task automatic test_wrap;
      run_req(1'b0, 3'b010, 32'hFFFF_F010, 32'h0);
      checks++; if (t_addr !== 10'd4 || t_dr !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL wrap got addr=%0d dr=%h exp 4/cafef00d", t_addr, t_dr); end
   endtask

   task automatic test_back_to_back;
      int a0;
      run_req(1'b0, 3'b010, 32'h0000_0000, 32'h0);
      a0 = t_acc;
      checks++; if (t_dr !== 32'hBEEF_5678) begin failures++; $display("FAIL b2b_first got %h exp beef5678", t_dr); end
      run_req(1'b0, 3'b010, 32'h0000_0004, 32'h0);
      checks++; if (t_acc - a0 !== 4) begin failures++; $display("FAIL b2b_spacing got %0d exp 4", t_acc - a0); end
      checks++; if (t_dr !== 32'h1122_AA44) begin failures++; $display("FAIL b2b_second got %h exp 1122aa44", t_dr); end
   endtask

   task automatic test_reset_rmw;
      int we_seen;
      int n;
      we_seen = 0;
      n = 0;
      poke(10'd3, 32'hA1B2_C3D4);
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      req_valid = 1'b1; MemRW = 1'b1; funct3 = 3'b000; ALU_addr = 32'h0000_000D; DataW = 32'h0000_0055;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (mem_we) we_seen++;
      @(posedge clk);
      #1;
      if (mem_we) we_seen++;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0 || misalign !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) begin
         failures++; $display("FAIL rmw_rst_ctrl got rv=%b mis=%b we=%b rdy=%b exp 0/0/0/1", resp_valid, misalign, mem_we, req_ready); end
      checks++; if (DataR !== 32'h0 || mem_wdata !== 32'h0 || mem_addr !== 10'h0) begin
         failures++; $display("FAIL rmw_rst_data got DataR=%h wdata=%h addr=%h exp 0", DataR, mem_wdata, mem_addr); end
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (mem_we) we_seen++; end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (mem_we) we_seen++; end
      checks++; if (we_seen !== 0) begin failures++; $display("FAIL rmw_rst_we got %0d exp 0", we_seen); end
      checks++; if (dmem[3] !== 32'hA1B2_C3D4) begin failures++; $display("FAIL rmw_rst_mem got %h exp a1b2c3d4", dmem[3]); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmw_rst_ready got %b exp 1", req_ready); end
      run_req(1'b0, 3'b010, 32'h0000_000C, 32'h0);
      checks++; if (t_dr !== 32'hA1B2_C3D4 || t_lat !== 3 || t_mis !== 1'b0) begin
         failures++; $display("FAIL post_rst_lw got %h lat %0d mis %b exp a1b2c3d4/3/0", t_dr, t_lat, t_mis); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sb();
      test_sh_sw();
      test_misalign();
      test_wrap();
      test_back_to_back();
      test_reset_rmw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
